// File: rtl/lns_loader_pkg.sv
// Shared definitions for the LNS instruction-memory loader: state encoding,
// default frame sync byte, and instruction memory geometry.
package lns_loader_pkg;

  localparam int         IMEM_DEPTH   = 1024;
  localparam int         WORD_W       = 16;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_CNT_HI = 3'd1,
    LDR_CNT_LO = 3'd2,
    LDR_DAT_HI = 3'd3,
    LDR_DAT_LO = 3'd4,
    LDR_CSUM   = 3'd5,
    LDR_DONE   = 3'd6,
    LDR_ERR    = 3'd7
  } ldr_state_e;

  // Running frame checksum is a plain XOR over every data byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/lns_word_assembler.sv
// Joins a hi/lo byte pair into one big-endian instruction word and presents it
// as a registered single-cycle memory write.
module lns_word_assembler
  import lns_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strobe_i,
  input  logic [7:0]        hi_i,
  input  logic [7:0]        lo_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [WORD_W-1:0] wdata_o
);

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;

  // A strobe coinciding with reset is dropped: reset owns the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= strobe_i;
      if (strobe_i) begin
        addr_q  <= addr_i;
        wdata_q <= {hi_i, lo_i};
      end
    end
  end

  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/lns_imem_loader.sv
// Framed byte-stream loader for the LNS instruction memory; keeps the CPU held
// in reset until a complete frame with a matching checksum has been written.
module lns_imem_loader
  import lns_loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  input  logic              reload
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  ldr_state_e        state_q;
  logic [7:0]        cnt_hi_q;
  logic [15:0]       count_q;
  logic [7:0]        hi_q;
  logic [7:0]        csum_q;
  logic [ADDR_W:0]   idx_q;
  logic              rx_ready_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic              wr_stb;
  logic [16:0]       n_ext;
  logic [15:0]       idx_next_ext;

  assign accept       = rx_valid && rx_ready_q;
  assign wr_stb       = accept && (state_q == LDR_DAT_LO);
  assign n_ext        = {1'b0, cnt_hi_q, rx_data};
  assign idx_next_ext = 16'(idx_q) + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LDR_IDLE;
      cnt_hi_q   <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      rx_ready_q <= 1'b1;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        LDR_IDLE: begin
          if (accept && rx_data == SYNC) begin
            state_q <= LDR_CNT_HI;
          end
        end
        LDR_CNT_HI: begin
          if (accept) begin
            cnt_hi_q <= rx_data;
            state_q  <= LDR_CNT_LO;
          end
        end
        LDR_CNT_LO: begin
          if (accept) begin
            count_q <= {cnt_hi_q, rx_data};
            csum_q  <= '0;
            idx_q   <= '0;
            // Counts beyond the memory depth would wrap the address; reject up front.
            if (n_ext > MAX_WORDS) begin
              state_q    <= LDR_ERR;
              error_q    <= 1'b1;
              rx_ready_q <= 1'b0;
            end else if (n_ext == 17'd0) begin
              state_q <= LDR_CSUM;
            end else begin
              state_q <= LDR_DAT_HI;
            end
          end
        end
        LDR_DAT_HI: begin
          if (accept) begin
            hi_q    <= rx_data;
            csum_q  <= csum_step(csum_q, rx_data);
            state_q <= LDR_DAT_LO;
          end
        end
        LDR_DAT_LO: begin
          if (accept) begin
            csum_q <= csum_step(csum_q, rx_data);
            idx_q  <= idx_q + 1'b1;
            if (idx_next_ext == count_q) begin
              state_q <= LDR_CSUM;
            end else begin
              state_q <= LDR_DAT_HI;
            end
          end
        end
        LDR_CSUM: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (rx_data == csum_q) begin
              state_q    <= LDR_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= LDR_ERR;
              error_q <= 1'b1;
            end
          end
        end
        LDR_DONE: begin
          if (reload) begin
            state_q    <= LDR_IDLE;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
            rx_ready_q <= 1'b1;
          end
        end
        LDR_ERR: begin
          if (reload) begin
            state_q    <= LDR_IDLE;
            error_q    <= 1'b0;
            rx_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= LDR_IDLE;
          rx_ready_q <= 1'b1;
          cpu_hold_q <= 1'b1;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

  lns_word_assembler #(
    .ADDR_W (ADDR_W)
  ) u_word_assembler (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (wr_stb),
    .hi_i     (hi_q),
    .lo_i     (rx_data),
    .addr_i   (idx_q[ADDR_W-1:0]),
    .we_o     (mem_we),
    .addr_o   (mem_addr),
    .wdata_o  (mem_wdata)
  );

  assign rx_ready     = rx_ready_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = idx_q;

endmodule

// File: tb/tb_lns_imem_loader.sv
// Scoreboard bench for lns_imem_loader: frames are built from word lists, the
// expected writes and frame outcome follow directly from the frame rules.
module tb_lns_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              reload = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;

  lns_imem_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .reload       (reload)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.idx));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
        check("wr_words_loaded", 32'(words_loaded), 32'(e.idx + 1));
      end
    end
    if (!reset) check("done_error_exclusive", 32'(done & error), 32'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && w <= 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w > 20) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // Builds and sends one frame; expected writes and outcome come from the frame rules.
  task automatic send_frame(input int n, input logic [15:0] data[$], input bit bad_csum, input int max_gap);
    logic [7:0] csum;
    logic [15:0] nn;
    bit ok;
    nn   = 16'(n);
    csum = 8'h00;
    ok   = (n <= DEPTH) && !bad_csum;
    send_byte(8'hA5, $urandom_range(0, max_gap));
    send_byte(nn[15:8], $urandom_range(0, max_gap));
    send_byte(nn[7:0], 0);
    if (n > DEPTH) begin
      rx_valid = 1'b0;
      check("big_count_error", 32'(error), 32'd1);
      check("big_count_done", 32'(done), 32'd0);
      check("big_count_rx_ready", 32'(rx_ready), 32'd0);
      check("big_count_cpu_hold", 32'(cpu_hold), 32'd1);
      return;
    end
    if (max_gap > 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.idx  = i;
      e.data = data[i];
      csum   = csum ^ data[i][15:8] ^ data[i][7:0];
      send_byte(data[i][15:8], $urandom_range(0, max_gap));
      exp_q.push_back(e);
      send_byte(data[i][7:0], $urandom_range(0, max_gap));
    end
    send_byte(bad_csum ? (csum ^ 8'h01) : csum, 0);
    rx_valid = 1'b0;
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("frame_done", 32'(done), 32'(ok));
    check("frame_error", 32'(error), 32'(!ok));
    check("frame_cpu_hold", 32'(cpu_hold), 32'(!ok));
    check("frame_rx_ready", 32'(rx_ready), 32'd0);
    check("frame_words_loaded", 32'(words_loaded), 32'(n));
  endtask

  task automatic do_reload();
    rx_valid = 1'b0;
    reload   = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload_rx_ready", 32'(rx_ready), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    check("reload_error", 32'(error), 32'd0);
    check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    logic [15:0] d[$];
    logic [7:0]  g;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Two-word frame, good and then bad checksum.
    d = '{16'h1234, 16'hABCD};
    send_frame(2, d, 1'b0, 0);
    do_reload();
    send_frame(2, d, 1'b1, 0);
    do_reload();

    // Leading garbage is discarded, then an empty frame.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    d = {};
    send_frame(0, d, 1'b0, 0);
    do_reload();

    // Oversized count rejected right after count_lo.
    send_frame(1025, d, 1'b0, 0);
    do_reload();

    // Reset after the hi byte of word 1: only word 0 lands.
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    exp_q.push_back('{idx: 0, data: 16'hBEEF});
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_byte(8'h77, 0);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midframe_reset");
    reset = 1'b0;
    check("midframe_writes_drained", 32'(exp_q.size()), 32'd0);
    d = '{16'hA5A5, 16'h0102, 16'hFFFF};
    send_frame(3, d, 1'b0, 0);
    do_reload();

    // Randomized frames with gaps, corruption and garbage prefixes.
    for (int f = 0; f < 25; f++) begin
      int n;
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(0, 1));
      end
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1025, 65535)) : int'($urandom_range(0, 12));
      d = {};
      if (n <= DEPTH) for (int i = 0; i < n; i++) d.push_back(16'($urandom));
      send_frame(n, d, ($urandom_range(0, 6) == 0), 2);
      do_reload();
    end

    // Full-rate fill of the whole memory, data equals address.
    d = {};
    for (int i = 0; i < DEPTH; i++) d.push_back(16'(i));
    send_frame(DEPTH, d, 1'b0, 0);
    do_reload();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lns_imem_loader.md
Name: lns_imem_loader

Overview:
Program loader for the LNS pipeline's 1024x16 instruction memory. The pipeline only reads instruction memory; this block is the writer. It accepts a framed byte stream, assembles big-endian 16-bit words and writes them to consecutive instruction addresses from 0. It holds the CPU in reset (cpu_hold) until a frame loads with a valid checksum.

Parameters:
ADDR_W, 10, instruction memory address width (depth = 2^ADDR_W words)
SYNC, 8'hA5, frame start byte

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  ADDR_W  write address
mem_wdata  out  16  write data
cpu_hold  out  1  holds the CPU in reset while high
done  out  1  frame loaded and checksum matched (level)
error  out  1  frame rejected (level)
words_loaded  out  ADDR_W+1  number of words written in the current frame
reload  in  1  from DONE or ERR, return to IDLE for a new frame

Behaviour:
- Byte acceptance: a byte is accepted on a posedge where rx_valid && rx_ready. Bytes may arrive back-to-back every cycle.
- rx_ready is 1 in IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO and CSUM. It is 0 in DONE and ERR.
- Frame format: SYNC, count_hi, count_lo, then N words (N = {count_hi,count_lo}), each sent hi byte then lo byte, then one checksum byte. The checksum is the XOR of all 2N data bytes (it is 8'h00 when N=0).
- States and transitions:
  - IDLE: a SYNC byte goes to CNT_HI. Any other byte is discarded and the state stays IDLE.
  - CNT_HI: latch count_hi, go to CNT_LO.
  - CNT_LO: latch count_lo, clear the checksum accumulator and word index.
    - N > 2^ADDR_W: go to ERR.
    - N = 0: go to CSUM.
    - Otherwise: go to DAT_HI.
  - DAT_HI: latch the hi byte, go to DAT_LO.
  - DAT_LO: on the lo byte, go to DAT_HI, or to CSUM when index+1 == N.
  - CSUM: if the byte equals the accumulator, go to DONE; otherwise go to ERR.
  - DONE / ERR: stay until reload=1, then go to IDLE (reload is sampled only in these states).
- Inside a frame, a SYNC value is ordinary data. There is no resync mid-frame.
- Write timing, per accepted lo byte:
  - The cycle after acceptance: mem_we=1, mem_addr = index, mem_wdata = {hi,lo}.
  - words_loaded increments in that same cycle.
  - mem_we is deasserted the following cycle unless another lo byte was accepted. Writes are never merged or dropped.
- The checksum accumulator XORs every accepted data byte (hi and lo).
- mem_addr, mem_wdata and mem_we are registered outputs.
- done and error are registered. They assert the cycle after the checksum byte (or the bad count) is accepted. At most one of them is high at any time.
- cpu_hold is 1 in every state except DONE; it is 0 only while in DONE. ERR keeps cpu_hold=1. reload from DONE reasserts cpu_hold the next cycle.
- Reset values: state IDLE, rx_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, error 0, words_loaded 0.
- Reset mid-frame: return to IDLE immediately. Words already written are not erased. A pending mem_we is suppressed.
- Address wrap: cannot occur, because N is bounded by 2^ADDR_W in CNT_LO. N = 2^ADDR_W exactly is legal and fills memory.

Decomposition:
- Shared package lns_loader_pkg holds:
  - state encoding LDR_IDLE..LDR_ERR (3 bits);
  - SYNC default;
  - IMEM_DEPTH = 1024.
- One natural sub-module: lns_word_assembler, which takes the hi/lo byte pair plus a strobe and produces the registered {word, we, addr}. The FSM stays in the top module.

Test Plan:
- Frame A5 00 02 12 34 AB CD 40 (0x12^0x34^0xAB^0xCD = 0x40) -> mem writes addr0=0x1234 and addr1=0xABCD. done=1, cpu_hold=0, words_loaded=2.
- Same frame with checksum 41 -> both words still written. error=1, done=0, cpu_hold stays 1. Then reload -> IDLE, rx_ready=1.
- Leading bytes 00 FF 5A, then A5 00 00 00 -> garbage ignored, no mem_we, done=1, words_loaded=0.
- A5 04 01 (N=1025) -> error=1 the cycle after count_lo is accepted. No mem_we ever.
- Reset asserted after the hi byte of word 1 in a 3-word frame -> only addr0 written. Outputs return to reset values. A fresh valid frame then loads correctly.
- Full-rate streaming (rx_valid held high, N=1024 with data = index) -> 1024 single-cycle mem_we pulses, with addr k = data k, and done=1.
